// File: rtl/boot_loader.sv
// Framed UART program loader: parses SYNC/LEN/payload/CHK frames from uart_rx,
// writes little-endian 32-bit words into instruction memory and gates the core via cpu_hold.
module boot_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         ADDR_W         = 8,
  parameter int         TIMEOUT_CYCLES = 2_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [1:0]        load_err,
  output logic [7:0]        words_loaded
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE} state_t;

  state_t             r_state;
  logic [7:0]         r_len;
  logic [7:0]         r_acc;
  logic [7:0]         r_words;
  logic [1:0]         r_lane;
  logic [23:0]        r_word;
  logic [GAP_W-1:0]   r_gap;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic               r_hold;
  logic               r_done;
  logic [1:0]         r_err;

  logic w_active;
  logic w_timeout;

  assign w_active  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
  // A byte on the expiring cycle wins over the timeout.
  assign w_timeout = w_active && !rx_dv && (r_gap == GAP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_acc   <= '0;
      r_words <= '0;
      r_lane  <= '0;
      r_word  <= '0;
      r_gap   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 2'b00;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;

      if (!w_active || rx_dv) r_gap <= '0;
      else                    r_gap <= r_gap + GAP_W'(1);

      if (w_timeout) begin
        r_state <= S_IDLE;
        r_err   <= 2'b10;
      end else if (rx_dv) begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (rx_byte == SYNC_BYTE) begin
              r_state <= S_LEN;
              r_hold  <= 1'b1;
              r_err   <= 2'b00;
              r_acc   <= '0;
              r_lane  <= '0;
              r_words <= '0;
            end
          end
          S_LEN: begin
            r_len   <= rx_byte;
            r_state <= (rx_byte == 8'd0) ? S_CHK : S_DATA;
          end
          S_DATA: begin
            r_acc  <= r_acc + rx_byte;
            r_lane <= r_lane + 2'd1;
            case (r_lane)
              2'd0: r_word[7:0]   <= rx_byte;
              2'd1: r_word[15:8]  <= rx_byte;
              2'd2: r_word[23:16] <= rx_byte;
              default: begin
                r_we    <= 1'b1;
                r_addr  <= ADDR_W'(r_words);
                r_wdata <= {rx_byte, r_word};
                r_words <= r_words + 8'd1;
                if (r_words + 8'd1 == r_len) r_state <= S_CHK;
              end
            endcase
          end
          S_CHK: begin
            if (rx_byte == r_acc) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_err   <= 2'b01;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign cpu_hold     = r_hold;
  assign load_done    = r_done;
  assign load_err     = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: frame-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized frames.
module tb_boot_loader;
  localparam int         T    = 300;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic [1:0]  load_err;
  logic [7:0]  words_loaded;

  boot_loader #(.SYNC_BYTE(SYNC), .ADDR_W(8), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit run_cmp  = 1'b0;
  logic [39:0] wr_q[$];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks byte position within a frame rather than a state machine.
  bit         m_in_frame;
  int         m_pos, m_len, m_gap;
  logic [7:0] m_sum;
  logic [7:0] m_buf[4];
  logic       e_we, e_hold, e_done;
  logic [7:0] e_addr, e_words;
  logic [31:0] e_wdata;
  logic [1:0] e_err;

  task automatic m_reset();
    m_in_frame = 1'b0; m_pos = 0; m_len = 0; m_gap = 0; m_sum = 8'h00;
    e_we = 1'b0; e_addr = 8'h00; e_wdata = 32'h0; e_hold = 1'b1;
    e_done = 1'b0; e_err = 2'b00; e_words = 8'h00;
  endtask

  task automatic m_step(input logic dv, input logic [7:0] b);
    e_we = 1'b0;
    e_done = 1'b0;
    if (m_in_frame) begin
      if (dv) begin
        m_gap = 0;
        if (m_pos == 0) begin
          m_len = int'(b);
          m_pos = 1;
        end else if (m_pos <= 4 * m_len) begin
          m_buf[(m_pos - 1) % 4] = b;
          m_sum = m_sum + b;
          if (m_pos % 4 == 0) begin
            e_we    = 1'b1;
            e_addr  = 8'(m_pos / 4 - 1);
            e_wdata = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
            e_words = 8'(m_pos / 4);
          end
          m_pos++;
        end else begin
          if (b == m_sum) begin
            e_done = 1'b1;
            e_hold = 1'b0;
          end else begin
            e_err = 2'b01;
          end
          m_in_frame = 1'b0;
        end
      end else begin
        m_gap++;
        if (m_gap == T) begin
          m_in_frame = 1'b0;
          m_gap = 0;
          e_err = 2'b10;
        end
      end
    end else if (dv && b == SYNC) begin
      m_in_frame = 1'b1;
      m_pos = 0; m_sum = 8'h00; m_gap = 0;
      e_words = 8'h00; e_err = 2'b00; e_hold = 1'b1;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else          m_step(rx_dv, rx_byte);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (run_cmp) begin
        chk("mem_we", 40'(mem_we), 40'(e_we));
        if (e_we) begin
          chk("mem_addr", 40'(mem_addr), 40'(e_addr));
          chk("mem_wdata", 40'(mem_wdata), 40'(e_wdata));
        end
        chk("cpu_hold", 40'(cpu_hold), 40'(e_hold));
        chk("load_done", 40'(load_done), 40'(e_done));
        chk("load_err", 40'(load_err), 40'(e_err));
        chk("words_loaded", 40'(words_loaded), 40'(e_words));
        if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at a negedge; returns at a later negedge.
  task automatic send(input logic [7:0] b, input int idle);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(negedge clk);
    rx_dv   = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] s[$], input int idle);
    for (int i = 0; i < s.size(); i++) send(s[i], (i == s.size() - 1) ? 0 : idle);
  endtask

  logic [7:0] good_fr[$];
  logic [7:0] bad_fr[$];
  logic [7:0] fr[$];

  initial begin
    good_fr = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'hD6};
    bad_fr  = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'hD7};

    #1 reset_n = 1'b0;
    run_cmp = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_hold", 40'(cpu_hold), 40'd1);
    chk("rst_we", 40'(mem_we), 40'd0);
    chk("rst_err", 40'(load_err), 40'd0);
    chk("rst_words", 40'(words_loaded), 40'd0);
    reset_n = 1'b1;
    @(negedge clk);
    wr_q.delete();
    send(8'h13, 2);
    send(8'hFF, 2);
    chk("idle_no_write", 40'(wr_q.size()), 40'd0);

    // Good frame
    wr_q.delete();
    send_seq(good_fr, 3);
    chk("good_done", 40'(load_done), 40'd1);
    chk("good_hold", 40'(cpu_hold), 40'd0);
    chk("good_words", 40'(words_loaded), 40'd2);
    @(negedge clk);
    chk("good_done_pulse", 40'(load_done), 40'd0);
    chk("good_nwr", 40'(wr_q.size()), 40'd2);
    if (wr_q.size() == 2) begin
      chk("good_wr0", wr_q[0], {8'h00, 32'h00100013});
      chk("good_wr1", wr_q[1], {8'h01, 32'h00200093});
    end

    // Bad checksum
    wr_q.delete();
    send_seq(bad_fr, 1);
    chk("bad_err", 40'(load_err), 40'd1);
    chk("bad_hold", 40'(cpu_hold), 40'd1);
    chk("bad_done", 40'(load_done), 40'd0);
    @(negedge clk);
    chk("bad_nwr", 40'(wr_q.size()), 40'd2);

    // Timeout exactly T cycles after the last byte
    wr_q.delete();
    send(SYNC, 2);
    send(8'h01, 2);
    send(8'h13, 0);
    repeat (T - 1) @(negedge clk);
    chk("to_not_yet", 40'(load_err), 40'd0);
    @(negedge clk);
    chk("to_err", 40'(load_err), 40'd2);
    chk("to_hold", 40'(cpu_hold), 40'd1);
    chk("to_nwr", 40'(wr_q.size()), 40'd0);
    send_seq(good_fr, 2);
    chk("to_clear_err", 40'(load_err), 40'd0);
    chk("to_clear_done", 40'(load_done), 40'd1);

    // Byte arriving on the expiring cycle wins
    wr_q.delete();
    send(SYNC, 1);
    send(8'h01, 1);
    send(8'h13, 0);
    repeat (T - 1) @(negedge clk);
    send(8'h00, 1);
    send(8'h00, 1);
    send(8'h00, 1);
    send(8'h13, 0);
    chk("edge_done", 40'(load_done), 40'd1);
    chk("edge_err", 40'(load_err), 40'd0);
    @(negedge clk);
    chk("edge_nwr", 40'(wr_q.size()), 40'd1);
    if (wr_q.size() == 1) chk("edge_wr0", wr_q[0], {8'h00, 32'h00000013});

    // Empty frame, then reload from DONE
    wr_q.delete();
    fr = '{8'hA5, 8'h00, 8'h00};
    send_seq(fr, 0);
    chk("empty_done", 40'(load_done), 40'd1);
    chk("empty_hold", 40'(cpu_hold), 40'd0);
    send(SYNC, 0);
    chk("reload_hold", 40'(cpu_hold), 40'd1);
    send(8'h00, 1);
    send(8'h00, 0);
    chk("reload_done", 40'(load_done), 40'd1);
    chk("empty_nwr", 40'(wr_q.size()), 40'd0);

    // Reset mid-frame
    fr = '{8'hA5, 8'h02, 8'h13, 8'h00};
    send_seq(fr, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_hold", 40'(cpu_hold), 40'd1);
    chk("mid_rst_words", 40'(words_loaded), 40'd0);
    chk("mid_rst_we", 40'(mem_we), 40'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr_q.delete();
    send_seq(good_fr, 2);
    @(negedge clk);
    chk("post_rst_nwr", 40'(wr_q.size()), 40'd2);
    if (wr_q.size() > 0) chk("post_rst_addr0", 40'(wr_q[0][39:32]), 40'd0);

    // Randomized frames
    for (int it = 0; it < 60; it++) begin
      int len, mode, cut;
      logic [7:0] sum;
      fr.delete();
      repeat ($urandom_range(0, 2)) fr.push_back(8'($urandom));
      len  = $urandom_range(0, 5);
      mode = $urandom_range(0, 9);
      sum  = 8'h00;
      fr.push_back(SYNC);
      fr.push_back(8'(len));
      for (int j = 0; j < 4 * len; j++) begin
        logic [7:0] b;
        b = 8'($urandom);
        sum = sum + b;
        fr.push_back(b);
      end
      fr.push_back((mode == 1) ? sum ^ 8'(1 << $urandom_range(0, 7)) : sum);
      cut = $urandom_range(1, fr.size() - 1);
      for (int j = 0; j < fr.size(); j++) begin
        if ((mode == 0 || mode == 2) && j == cut) break;
        send(fr[j], ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 8));
      end
      if (mode == 0) repeat (T + 3) @(negedge clk);
      if (mode == 2) begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
      end
      repeat (3) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
